// File: rtl/lsb_debounce_pkg.sv
// lsb_debounce_pkg: register field positions and read-word packing for the debounce block.
package lsb_debounce_pkg;
  localparam int LSBD_SWI_LO_LSB = 0;
  localparam int LSBD_SWI_LO_MSB = 7;
  localparam int LSBD_BTN_LSB    = 8;
  localparam int LSBD_BTN_MSB    = 11;
  localparam int LSBD_PRESS_LSB  = 12;
  localparam int LSBD_PRESS_MSB  = 15;
  localparam int LSBD_SWI_HI_LSB = 16;
  localparam int LSBD_SWI_HI_MSB = 25;
  localparam int LSBD_REL_LSB    = 26;
  localparam int LSBD_REL_MSB    = 29;

  function automatic logic [31:0] lsbd_pack(input logic [3:0] rel, input logic [17:0] swi,
                                            input logic [3:0] press, input logic [3:0] btn);
    logic [31:0] w;
    w = '0;
    w[LSBD_SWI_LO_MSB:LSBD_SWI_LO_LSB] = swi[7:0];
    w[LSBD_BTN_MSB:LSBD_BTN_LSB]       = btn;
    w[LSBD_PRESS_MSB:LSBD_PRESS_LSB]   = press;
    w[LSBD_SWI_HI_MSB:LSBD_SWI_HI_LSB] = swi[17:8];
    w[LSBD_REL_MSB:LSBD_REL_LSB]       = rel;
    return w;
  endfunction
endpackage

// File: rtl/lsb_debounce_deb_cell.sv
// deb_cell: one-bit debouncer; level follows raw after DEB_TICKS consecutive differing ticks.
module deb_cell #(
  parameter int DEB_TICKS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic deb
);
  logic       deb_q, deb_d, last;
  logic [7:0] cnt_q, cnt_d;
  always_comb begin
    last  = tick && (raw != deb_q) && (cnt_q == 8'(DEB_TICKS - 1));
    deb_d = last ? raw : deb_q;
    cnt_d = (raw == deb_q || last) ? 8'd0 : tick ? cnt_q + 8'd1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q <= 1'b0;
      cnt_q <= 8'd0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end
  assign deb = deb_q;
endmodule

// File: rtl/lsb_debounce.sv
// lsb_debounce: debounces LSB button/switch inputs, detects button edges, exposes
// sticky press/release flags on the IO bus with write-1-to-clear.
module lsb_debounce
  import lsb_debounce_pkg::*;
#(
  parameter int TICK_DIV  = 50000,
  parameter int DEB_TICKS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  input  logic [3:0]  btn_in,
  input  logic [17:0] swi_in,
  output logic [3:0]  btn_deb,
  output logic [17:0] swi_deb,
  output logic [3:0]  btn_press,
  output logic        btn_evt
);
  localparam int DW = $clog2(TICK_DIV);
  logic [DW-1:0] div_q, div_d;
  logic          tick, rd, wr;
  logic [21:0]   raw, deb;
  logic [3:0]    prev_q, prev_d, press_q, press_d, press_f_q, press_f_d, rel_f_q, rel_f_d;
  logic [3:0]    clr_p, clr_r;
  logic          unused_data_in;
  assign tick = div_q == DW'(TICK_DIV - 1);
  assign raw  = {swi_in, btn_in};
  for (genvar i = 0; i < 22; i++) begin : g_cell
    deb_cell #(.DEB_TICKS(DEB_TICKS)) u_cell (
      .clk (clk),
      .rst (rst),
      .tick(tick),
      .raw (raw[i]),
      .deb (deb[i])
    );
  end
  // Edge pulses and flag sets land on the same clock edge; a set beats a same-cycle clear.
  always_comb begin
    rd        = stb & ~we;
    wr        = stb & we;
    div_d     = tick ? '0 : div_q + DW'(1);
    clr_p     = wr ? data_in[LSBD_PRESS_MSB:LSBD_PRESS_LSB] : 4'd0;
    clr_r     = wr ? data_in[LSBD_REL_MSB:LSBD_REL_LSB] : 4'd0;
    press_d   = deb[3:0] & ~prev_q;
    prev_d    = deb[3:0];
    press_f_d = (press_f_q & ~clr_p) | press_d;
    rel_f_d   = (rel_f_q & ~clr_r) | (~deb[3:0] & prev_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      prev_q    <= '0;
      press_q   <= '0;
      press_f_q <= '0;
      rel_f_q   <= '0;
    end else begin
      div_q     <= div_d;
      prev_q    <= prev_d;
      press_q   <= press_d;
      press_f_q <= press_f_d;
      rel_f_q   <= rel_f_d;
    end
  end
  assign unused_data_in = ^{data_in[31:30], data_in[25:16], data_in[11:0]};
  assign btn_deb   = deb[3:0];
  assign swi_deb   = deb[21:4];
  assign btn_press = press_q;
  assign btn_evt   = |press_f_q;
  assign ack       = stb;
  assign data_out  = rd ? lsbd_pack(rel_f_q, deb[21:4], press_f_q, deb[3:0]) : 32'd0;
endmodule

// File: tb/tb_lsb_debounce.sv
// tb_lsb_debounce: directed and random stimulus against a tick-counting reference model.
module tb_lsb_debounce;
  localparam int TD = 4;
  localparam int DT = 3;
  logic        clk = 0, rst = 1, stb = 0, we = 0;
  logic [31:0] data_in = 0;
  logic [3:0]  btn_in = 0;
  logic [17:0] swi_in = 0;
  logic [31:0] data_out;
  logic        ack, btn_evt;
  logic [3:0]  btn_deb, btn_press;
  logic [17:0] swi_deb;
  int errs = 0, checks = 0;
  int pc[4];
  bit armed = 0;
  // reference model: deb flips once DT tick edges have passed since raw last matched deb
  int c;
  int last_eq[22];
  logic [21:0] m_deb;
  logic [3:0]  m_prev, m_press, m_pf, m_rf;

  always #5 clk = ~clk;

  lsb_debounce #(.TICK_DIV(TD), .DEB_TICKS(DT)) dut (
    .clk(clk), .rst(rst), .stb(stb), .we(we), .data_in(data_in), .data_out(data_out),
    .ack(ack), .btn_in(btn_in), .swi_in(swi_in), .btn_deb(btn_deb), .swi_deb(swi_deb),
    .btn_press(btn_press), .btn_evt(btn_evt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [21:0] raw;
    logic [3:0]  clr_p, clr_r;
    int nt;
    raw = {swi_in, btn_in};
    if (rst) begin
      c = 0; m_deb = 0; m_prev = 0; m_press = 0; m_pf = 0; m_rf = 0;
      for (int i = 0; i < 22; i++) last_eq[i] = -1;
    end else begin
      clr_p = (stb && we) ? data_in[15:12] : 4'd0;
      clr_r = (stb && we) ? data_in[29:26] : 4'd0;
      m_press = m_deb[3:0] & ~m_prev;
      m_pf = (m_pf & ~clr_p) | m_press;
      m_rf = (m_rf & ~clr_r) | (~m_deb[3:0] & m_prev);
      m_prev = m_deb[3:0];
      for (int i = 0; i < 22; i++) begin
        if (raw[i] == m_deb[i]) last_eq[i] = c;
        else if (c % TD == TD - 1) begin
          nt = (c + 1) / TD - (last_eq[i] + 1) / TD;
          if (nt >= DT) begin
            m_deb[i] = raw[i];
            last_eq[i] = c;
          end
        end
      end
      c++;
    end
  endtask

  task automatic step();
    logic [31:0] exp_rd;
    @(negedge clk);
    if (armed) begin
      exp_rd = (stb && !we) ? {2'b0, m_rf, m_deb[21:12], m_pf, m_deb[3:0], m_deb[11:4]} : 32'd0;
      chk("btn_deb", 32'(btn_deb), 32'(m_deb[3:0]));
      chk("swi_deb", 32'(swi_deb), 32'(m_deb[21:4]));
      chk("btn_press", 32'(btn_press), 32'(m_press));
      chk("btn_evt", 32'(btn_evt), 32'(|m_pf));
      chk("ack", 32'(ack), 32'(stb));
      chk("data_out", data_out, exp_rd);
      for (int b = 0; b < 4; b++) pc[b] += int'(btn_press[b]);
    end
    @(posedge clk);
    model_edge();
    armed = 1;
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus(input logic s, input logic w, input logic [31:0] d);
    stb = s; we = w; data_in = d;
  endtask

  task automatic wait_btn(input int b, input logic lvl, input string tag);
    int n;
    n = 0;
    while (btn_deb[b] !== lvl && n < 40) begin
      step();
      n++;
    end
    chk(tag, 32'(n >= 9 && n <= 12), 32'd1);
  endtask

  initial begin
    for (int b = 0; b < 4; b++) pc[b] = 0;
    steps(3);
    rst = 0;
    steps(2);
    // clean step on btn 0
    btn_in[0] = 1;
    wait_btn(0, 1'b1, "lat_clean");
    pc[0] = 0;
    steps(8);
    chk("press_cnt_clean", 32'(pc[0]), 32'd1);
    bus(1, 0, 0); #1;
    chk("rd_press0", 32'(data_out[12]), 32'd1);
    chk("rd_btn0", 32'(data_out[8]), 32'd1);
    chk("evt_clean", 32'(btn_evt), 32'd1);
    step(); bus(0, 0, 0);
    // bounce on btn 1
    pc[1] = 0;
    btn_in[1] = 1; steps(5);
    btn_in[1] = 0; steps(5);
    chk("bounce_hold", 32'(btn_deb[1]), 32'd0);
    btn_in[1] = 1;
    wait_btn(1, 1'b1, "lat_bounce");
    steps(4);
    chk("press_cnt_bounce", 32'(pc[1]), 32'd1);
    // clear, then clear racing a new press on btn 0
    bus(1, 1, 32'h0000_3000); step(); bus(0, 0, 0); #1;
    chk("evt_cleared", 32'(btn_evt), 32'd0);
    btn_in[0] = 0;
    wait_btn(0, 1'b0, "lat_fall0");
    btn_in[0] = 1;
    wait_btn(0, 1'b1, "lat_repress0");
    bus(1, 1, 32'h0000_1000); step(); bus(0, 0, 0); #1;
    chk("race_set_wins", 32'(btn_evt), 32'd1);
    chk("race_pulse", 32'(btn_press[0]), 32'd1);
    // release on btn 2
    btn_in[2] = 1;
    wait_btn(2, 1'b1, "lat_rise2");
    steps(3);
    pc[2] = 0;
    btn_in[2] = 0;
    wait_btn(2, 1'b0, "lat_fall2");
    steps(3);
    chk("rel_no_pulse", 32'(pc[2]), 32'd0);
    bus(1, 0, 0); #1;
    chk("rd_rel2", 32'(data_out[28]), 32'd1);
    step();
    bus(1, 1, 32'h1000_0000); step(); bus(1, 0, 0); #1;
    chk("rel2_cleared", 32'(data_out[28]), 32'd0);
    step(); bus(0, 0, 0);
    // switch map
    swi_in = 18'h2A5C3;
    steps(16);
    bus(1, 0, 0); #1;
    chk("swi_lo", 32'(data_out[7:0]), 32'hC3);
    chk("swi_hi", 32'(data_out[25:16]), 32'h2A5);
    chk("ack_hi", 32'(ack), 32'd1);
    step(); bus(0, 0, 0); #1;
    chk("rd_idle", data_out, 32'd0);
    chk("ack_lo", 32'(ack), 32'd0);
    // reset mid-qualification with btn 3 held
    btn_in[3] = 1;
    steps(6);
    rst = 1; bus(1, 0, 0);
    steps(2); #1;
    chk("rst_btn", 32'(btn_deb), 32'd0);
    chk("rst_swi", 32'(swi_deb), 32'd0);
    chk("rst_press", 32'(btn_press), 32'd0);
    chk("rst_evt", 32'(btn_evt), 32'd0);
    chk("rst_rd", data_out, 32'd0);
    rst = 0; bus(0, 0, 0);
    pc[3] = 0;
    wait_btn(3, 1'b1, "lat_rst");
    steps(4);
    chk("press_cnt_rst", 32'(pc[3]), 32'd1);
    // random traffic
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 24) == 0) btn_in ^= 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) swi_in ^= 18'(1 << $urandom_range(0, 17));
      stb = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      data_in = $urandom();
      rst = ($urandom_range(0, 599) == 0);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/lsb_debounce.md
Name: lsb_debounce

Overview:
- Debounces and edge-detects the synchronised button and switch vectors produced by the LED/switch/button I/O block (btn_out[3:0], swi_out[17:0]).
- Provides clean levels, one-cycle press pulses, and sticky press/release flags.
- Sticky flags are readable and write-1-clearable over the same IO-bus protocol (stb/we/ack).
- Sits directly downstream of the LSB block. Software and the reset/abort logic consume its outputs instead of the raw synchronised inputs.

Parameters:
- TICK_DIV, 50000: clk cycles per debounce sample tick (1 ms at 50 MHz). Legal range is 2 or more.
- DEB_TICKS, 10: consecutive ticks an input must differ from its debounced level before the level changes. Legal range is 1 to 255.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- stb  in  1  IO-bus strobe for this device
- we  in  1  IO-bus write enable
- data_in  in  32  IO-bus write data
- data_out  out  32  IO-bus read data
- ack  out  1  IO-bus acknowledge
- btn_in  in  4  buttons, active-high, already clock-synchronised
- swi_in  in  18  switches, already clock-synchronised
- btn_deb  out  4  debounced button levels
- swi_deb  out  18  debounced switch levels
- btn_press  out  4  one-cycle pulse per debounced button rising edge
- btn_evt  out  1  OR of all sticky press flags, usable as an interrupt

Behaviour:
Prescaler
- Counter runs 0..TICK_DIV-1. tick=1 for exactly one cycle when the count equals TICK_DIV-1, then the count wraps to 0.
- Reset clears the count to 0.

Per-bit debounce cell (22 instances)
- State: deb (1 bit) and cnt (8 bits).
- Every cycle where raw==deb: cnt <= 0, regardless of tick. A glitch therefore restarts qualification.
- On tick with raw!=deb and cnt==DEB_TICKS-1: deb <= raw, cnt <= 0.
- On tick with raw!=deb otherwise: cnt <= cnt+1.
- Latency from a stable raw change to the deb change lies between (DEB_TICKS-1)*TICK_DIV+1 and DEB_TICKS*TICK_DIV cycles.

Edge detection
- btn_press[i] is a registered pulse. It is 1 in the cycle immediately after btn_deb[i] goes 0->1, and lasts exactly 1 cycle.
- A release sets a release flag only; it produces no pulse output.

Sticky flags
- press_f[3:0] and rel_f[3:0].
- Set on the corresponding debounced rising/falling edge (same cycle btn_press is registered).
- Cleared by a write with the corresponding bit set: data_in[15:12] clears press_f, data_in[29:26] clears rel_f.
- Set and clear in the same cycle: set wins.
- btn_evt = |press_f, combinational from flops.

Bus
- ack = stb, zero wait states.
- Read (stb & ~we), combinational:
  - data_out = {2'b0, rel_f[3:0], swi_deb[17:8], press_f[3:0], btn_deb[3:0], swi_deb[7:0]}
  - Field positions: [31:30]=0, [29:26] rel_f, [25:16] swi_deb[17:8], [15:12] press_f, [11:8] btn_deb, [7:0] swi_deb[7:0].
  - Bit placement of btn/swi matches the LSB read layout except bits [31:26] and [15:12].
- data_out = 0 whenever a read is not active.
- Write bits other than the clear fields are ignored.

Reset
- Clears deb, cnt, prescaler, press pulses and flags: all outputs 0, btn_evt=0.
- Inputs high at reset release are qualified normally. A button held through reset therefore produces one press pulse and flag after the debounce latency.
- Reset asserted mid-qualification discards the partial count.

Decomposition:
- Shared include/package holds the register field constants:
  - LSBD_SWI_LO = 7:0
  - LSBD_BTN = 11:8
  - LSBD_PRESS = 15:12
  - LSBD_SWI_HI = 25:16
  - LSBD_REL = 29:26
- One natural sub-module, deb_cell:
  - Ports: clk, rst, tick, raw, deb.
  - Parameter: DEB_TICKS.
  - Instantiated via generate for 4 buttons and 18 switches.
- Prescaler, edge detect, flags and bus logic stay in the top module.

Test Plan:
All scenarios use TICK_DIV=4, DEB_TICKS=3.
- Clean step: btn_in[0] 0->1 and held 20 cycles -> btn_deb[0] rises 9..12 cycles later; btn_press[0] high exactly 1 cycle after; read returns data_out[12]=1, data_out[8]=1, btn_evt=1.
- Bounce: btn_in[1] toggles 1,0,1 each 5 cycles, then holds 1 -> no change during toggling; btn_deb[1] rises 9..12 cycles after the final stable edge; exactly one btn_press[1] pulse.
- Clear and race: press_f=4'b0001, write data_in=32'h0000_1000 -> flag reads 0, btn_evt=0. Repeat the write in the same cycle as a new press edge on btn 0 -> flag stays 1.
- Release: btn 2 debounced high, then btn_in[2]=0 held -> rel_f[2] set (data_out[28]=1); no btn_press pulse. Write data_in[28]=1 -> rel_f[2]=0.
- Switch map: swi_in=18'h2A5C3 held 16 cycles -> read data_out[7:0]=8'hC3, data_out[25:16]=10'h2A5; with stb=0, data_out=0; ack follows stb.
- Reset: btn_in[3]=1 held across rst pulse mid-qualification -> all outputs 0 during rst; after release btn_deb[3] rises 9..12 cycles later, followed by one press pulse.
